// File: rtl/c_ram_pkg.sv
// Shared sizing and FSM encoding for the C operand RAM path.
// The scheduler, the C RAM controller and the datapath all import this
// package so they agree on word count, address width and read latency.
package c_ram_pkg;

  localparam int WORDS  = 16;  // words per operand, 2**ADDR_W
  localparam int ADDR_W = 4;   // RAM address width
  localparam int ITER_W = 8;   // outer iteration count width
  localparam int RD_LAT = 2;   // read request -> valid data (ctrl reg + RAM)

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_PWAIT,
    S_READ,
    S_WAIT,
    S_STEP,
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/c_ram_scheduler.sv
// c_ram_scheduler: word-serial request sequencer for the C operand RAM.
// Per outer iteration it issues one lookahead read (word 0), then walks
// every word as read -> wait RD_LAT -> compute (dp_step/dp_ready) -> write.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, num_iter     launch a run of num_iter iterations (ignored if busy)
//   busy, done          run in progress / one-cycle completion pulse
//   write_ram, read_ram_1, read_ram_2 + *_address
//                       request strobes and addresses to the RAM controller
//   dp_prime            lookahead word is valid on the RAM output
//   dp_step, dp_ready   per-word handshake with the arithmetic datapath
//   iter_idx, word_idx  current outer iteration / word
//
// Every output is a register loaded from the next-state decode, so the
// outputs reflect the current state without any input-to-output path.
module c_ram_scheduler #(
  parameter int WORDS  = c_ram_pkg::WORDS,
  parameter int ADDR_W = c_ram_pkg::ADDR_W,
  parameter int ITER_W = c_ram_pkg::ITER_W,
  parameter int RD_LAT = c_ram_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iter,
  output logic              busy,
  output logic              done,
  output logic              write_ram,
  output logic              read_ram_1,
  output logic              read_ram_2,
  output logic [ADDR_W-1:0] write_address,
  output logic [ADDR_W-1:0] read_address_1,
  output logic [ADDR_W-1:0] read_address_2,
  output logic              dp_prime,
  output logic              dp_step,
  input  logic              dp_ready,
  output logic [ITER_W-1:0] iter_idx,
  output logic [ADDR_W-1:0] word_idx
);
  import c_ram_pkg::*;

  // latency counter holds RD_LAT-1 down to 0 (RD_LAT >= 1)
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  state_t            state, state_n;
  logic [LAT_W-1:0]  lat, lat_n;
  logic [ITER_W-1:0] n_iter, n_iter_n;
  logic [ITER_W-1:0] iter_n;
  logic [ADDR_W-1:0] word_n;

  always_comb begin
    state_n  = state;
    lat_n    = lat;
    n_iter_n = n_iter;
    iter_n   = iter_idx;
    word_n   = word_idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_iter != '0) begin
            n_iter_n = num_iter;
            iter_n   = '0;
            word_n   = '0;
            state_n  = S_PRIME;
          end else begin
            state_n  = S_DONE;
          end
        end
      end
      S_PRIME: begin
        state_n = S_PWAIT;
        lat_n   = LAT_LOAD;
      end
      S_PWAIT: begin
        if (lat == '0) state_n = S_READ;
        else           lat_n   = lat - 1'b1;
      end
      S_READ: begin
        state_n = S_WAIT;
        lat_n   = LAT_LOAD;
      end
      S_WAIT: begin
        if (lat == '0) state_n = S_STEP;
        else           lat_n   = lat - 1'b1;
      end
      S_STEP: begin
        if (dp_ready) state_n = S_WRITE;
      end
      S_WRITE: begin
        if (word_idx != LAST_WORD) begin
          word_n  = word_idx + 1'b1;
          state_n = S_READ;
        end else if (iter_idx < n_iter - ITER_W'(1)) begin
          word_n  = word_idx + 1'b1;  // wraps to 0
          iter_n  = iter_idx + 1'b1;
          state_n = S_PRIME;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // next-cycle output decode; only one of the request strobes can be set
  // because each maps to a distinct state
  logic busy_n, done_n, wr_n, rd1_n, rd2_n, prime_n, step_n;

  always_comb begin
    busy_n  = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n  = (state_n == S_DONE);
    wr_n    = (state_n == S_WRITE);
    rd1_n   = (state_n == S_READ);
    rd2_n   = (state_n == S_PRIME);
    prime_n = (state_n == S_PWAIT) && (lat_n == '0);
    step_n  = (state_n == S_STEP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      lat            <= '0;
      n_iter         <= '0;
      iter_idx       <= '0;
      word_idx       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      write_ram      <= 1'b0;
      read_ram_1     <= 1'b0;
      read_ram_2     <= 1'b0;
      dp_prime       <= 1'b0;
      dp_step        <= 1'b0;
      write_address  <= '0;
      read_address_1 <= '0;
      read_address_2 <= '0;
    end else begin
      state      <= state_n;
      lat        <= lat_n;
      n_iter     <= n_iter_n;
      iter_idx   <= iter_n;
      word_idx   <= word_n;
      busy       <= busy_n;
      done       <= done_n;
      write_ram  <= wr_n;
      read_ram_1 <= rd1_n;
      read_ram_2 <= rd2_n;
      dp_prime   <= prime_n;
      dp_step    <= step_n;
      // addresses only move with their strobe; they hold otherwise
      if (wr_n)  write_address  <= word_n;
      if (rd1_n) read_address_1 <= word_n;
      if (rd2_n) read_address_2 <= '0;  // lookahead always starts at word 0
    end
  end

endmodule

// File: tb/tb_c_ram_scheduler.sv
module tb_c_ram_scheduler;
  import c_ram_pkg::*;

  localparam int LAT = RD_LAT;
  localparam int K_RD2 = 0, K_PRIME = 1, K_RD1 = 2, K_WR = 3, K_DONE = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ITER_W-1:0] num_iter = '0;
  logic              dp_ready = 1'b1;
  logic              busy, done, write_ram, read_ram_1, read_ram_2;
  logic [ADDR_W-1:0] write_address, read_address_1, read_address_2;
  logic              dp_prime, dp_step;
  logic [ITER_W-1:0] iter_idx;
  logic [ADDR_W-1:0] word_idx;

  always #5 clk = ~clk;

  c_ram_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .num_iter(num_iter),
    .busy(busy), .done(done),
    .write_ram(write_ram), .read_ram_1(read_ram_1), .read_ram_2(read_ram_2),
    .write_address(write_address), .read_address_1(read_address_1),
    .read_address_2(read_address_2),
    .dp_prime(dp_prime), .dp_step(dp_step), .dp_ready(dp_ready),
    .iter_idx(iter_idx), .word_idx(word_idx)
  );

  typedef struct { int kind; int addr; int iter; int cyc; } ev_t;
  typedef struct { int n; int stall_at; int stall_len; int mid_start; int exp_done; } vec_t;

  ev_t q[$];
  int  vectors = 0, miscompares = 0;
  int  cyc = 0, t0 = 0;
  bit  active = 0, go_req = 0, mon_en = 0, busy_chk = 1;
  int  run_n = 0, stall_at = -1, stall_len = 0, mid_start = -1, exp_done = 0;
  int  step_cnt = 0, done_rel = -1, mrel = 0;
  bit  exp_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input int kind, input int addr, input int rel);
    ev_t e;
    if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected event kind %0d addr %0d at cycle %0d (expected none)",
               kind, addr, rel);
    end else begin
      e = q.pop_front();
      chk($sformatf("event kind @%0d", e.cyc), kind, e.kind);
      chk($sformatf("event cycle kind%0d", e.kind), rel, e.cyc);
      chk($sformatf("event addr kind%0d @%0d", e.kind, e.cyc), addr, e.addr);
      if (e.kind == K_RD2 || e.kind == K_RD1 || e.kind == K_WR) begin
        chk($sformatf("iter_idx @%0d", e.cyc), int'(iter_idx), e.iter);
        chk($sformatf("word_idx @%0d", e.cyc), int'(word_idx), e.addr);
      end
    end
  endtask

  // expected event stream, straight from the cycle timing of the block
  task automatic build(input int n, input int sa, input int sl);
    int t, st, ex;
    q.delete();
    t = 1;
    for (int it = 0; it < n; it++) begin
      q.push_back('{K_RD2, 0, it, t});
      q.push_back('{K_PRIME, 0, it, t + LAT});
      t += 1 + LAT;
      for (int w = 0; w < WORDS; w++) begin
        st = t + 1 + LAT;
        ex = (st == sa) ? sl : 0;
        q.push_back('{K_RD1, w, it, t});
        q.push_back('{K_WR, w, it, t + 2 + LAT + ex});
        t += 3 + LAT + ex;
      end
    end
    q.push_back('{K_DONE, 0, 0, t});
  endtask

  // stimulus driver: owns start, num_iter, dp_ready
  always @(posedge clk) begin
    #1;
    if (go_req) begin
      go_req   = 0;
      t0       = cyc;
      active   = 1;
      start    = 1'b1;
      num_iter = ITER_W'(run_n);
    end else begin
      start    = active && ((cyc - t0) == mid_start);
      num_iter = ITER_W'(5);
    end
    dp_ready = !(active && (cyc - t0) >= stall_at && (cyc - t0) < stall_at + stall_len);
  end

  // monitor / scoreboard consumer
  always @(negedge clk) begin
    if (mon_en) begin
      mrel = cyc - t0;
      chk("strobe exclusivity", int'(write_ram) + int'(read_ram_1) + int'(read_ram_2) > 1, 0);
      if (busy_chk) begin
        exp_busy = active && mrel >= 1 && mrel < exp_done;
        chk($sformatf("busy @%0d", mrel), int'(busy), int'(exp_busy));
      end
      if (dp_step) step_cnt++;
      if (read_ram_2) pop_chk(K_RD2, int'(read_address_2), mrel);
      if (dp_prime)   pop_chk(K_PRIME, 0, mrel);
      if (read_ram_1) pop_chk(K_RD1, int'(read_address_1), mrel);
      if (write_ram)  pop_chk(K_WR, int'(write_address), mrel);
      if (done) begin
        done_rel = mrel;
        pop_chk(K_DONE, 0, mrel);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " flags"}, int'({busy, done, write_ram, read_ram_1, read_ram_2, dp_prime, dp_step}), 0);
    chk({tag, " write_address"}, int'(write_address), 0);
    chk({tag, " read_address_1"}, int'(read_address_1), 0);
    chk({tag, " read_address_2"}, int'(read_address_2), 0);
    chk({tag, " iter_idx"}, int'(iter_idx), 0);
    chk({tag, " word_idx"}, int'(word_idx), 0);
  endtask

  task automatic run(input vec_t v);
    int i;
    build(v.n, v.stall_at, v.stall_len);
    stall_at  = v.stall_at;
    stall_len = v.stall_len;
    mid_start = v.mid_start;
    exp_done  = v.exp_done;
    run_n     = v.n;
    step_cnt  = 0;
    done_rel  = -1;
    go_req    = 1;
    i = 0;
    while (done_rel < 0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    if (done_rel < 0) begin
      miscompares++;
      $display("FAIL run n=%0d: done never seen, expected at cycle %0d", v.n, v.exp_done);
    end
    repeat (3) @(posedge clk);
    chk($sformatf("done cycle n=%0d", v.n), done_rel, v.exp_done);
    chk($sformatf("leftover events n=%0d", v.n), q.size(), 0);
    chk($sformatf("dp_step cycles n=%0d", v.n), step_cnt, WORDS * v.n + v.stall_len);
    #2;
    active = 0;
  endtask

  vec_t vecs[6];

  initial begin
    int i;
    vecs[0] = '{1, -1, 0, -1, 84};    // single iteration, dp_ready tied high
    vecs[1] = '{2, -1, 0, -1, 167};   // word wrap + second prime at 84
    vecs[2] = '{1, 22, 5, -1, 89};    // 5-cycle stall on word 3
    vecs[3] = '{1, -1, 0, 40, 84};    // start pulsed mid-run is ignored
    vecs[4] = '{0, -1, 0, -1, 1};     // zero iterations: done only
    vecs[5] = '{3, 100, 2, -1, 252};  // stall on word 2 of iteration 1

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1;

    foreach (vecs[k]) run(vecs[k]);

    // reset during STEP of word 7: abandon the word, then restart cleanly
    build(1, -1, 0);
    busy_chk  = 0;
    stall_at  = -1;
    stall_len = 0;
    mid_start = -1;
    run_n     = 1;
    done_rel  = -1;
    go_req    = 1;
    i = 0;
    do begin
      @(posedge clk);
      #2;
      i++;
    end while (!(active && (cyc - t0) == 42) && i < 300);
    chk("in STEP of word 7", int'(dp_step), 1);
    chk("word_idx before reset", int'(word_idx), 7);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    active = 0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk_zero("mid-run reset");
    busy_chk = 1;
    repeat (10) @(posedge clk);  // word 7 write-back must not appear
    run(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
